// File: rtl/instr_issue_unit_pkg.sv
// instr_pkg: shared definitions for the instruction issue unit.
//   - opcode constants
//   - bit positions of the fields inside the 32-bit instruction word
//   - FSM state type and encodings
//   - encode_instr(): packs the host-side fields into one instruction word
package instr_pkg;

  localparam logic [4:0] OP_MOV  = 5'd1;
  localparam logic [4:0] OP_ADD  = 5'd2;
  localparam logic [4:0] OP_MUL  = 5'd4;
  localparam logic [4:0] OP_OR   = 5'd5;
  localparam logic [4:0] OP_AND  = 5'd6;
  localparam logic [4:0] OP_XOR  = 5'd7;
  localparam logic [4:0] OP_XNOR = 5'd8;
  localparam logic [4:0] OP_NAND = 5'd9;
  localparam logic [4:0] OP_NOR  = 5'd10;
  localparam logic [4:0] OP_NOT  = 5'd11;

  // Highest opcode the core understands; anything above it is illegal.
  localparam logic [4:0] OP_MAX_LEGAL = OP_NOT;

  localparam int IR_OPER_LSB  = 27;
  localparam int IR_RDST_LSB  = 22;
  localparam int IR_RSRC1_LSB = 17;
  localparam int IR_IMM_BIT   = 16;
  localparam int IR_RSRC2_LSB = 11;
  localparam int IR_ISRC_LSB  = 0;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_ISSUE     = 2'd1;
  localparam state_t ST_WAIT_DONE = 2'd2;

  // In register mode the low 11 bits are always zero; isrc is ignored.
  function automatic logic [31:0] encode_instr(
    input logic [4:0]  oper,
    input logic [4:0]  rdst,
    input logic [4:0]  rsrc1,
    input logic [4:0]  rsrc2,
    input logic        imm_mode,
    input logic [15:0] isrc
  );
    logic [31:0] w;
    w = '0;
    w[IR_OPER_LSB  +: 5] = oper;
    w[IR_RDST_LSB  +: 5] = rdst;
    w[IR_RSRC1_LSB +: 5] = rsrc1;
    w[IR_IMM_BIT]        = imm_mode;
    if (imm_mode) begin
      w[IR_ISRC_LSB +: 16] = isrc;
    end else begin
      w[IR_RSRC2_LSB +: 5] = rsrc2;
    end
    return w;
  endfunction

endpackage

// File: rtl/instr_issue_unit_if.sv
// instr_issue_unit_if: host push channel plus core issue channel.
//   host side : in_valid/in_ready handshake with opcode, register and
//               immediate fields
//   core side : ir/ir_valid offered to the core, ir_ack accept, exec_done
// modport master is the host/core environment, modport slave the unit.
interface instr_issue_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_oper_type;
  logic [4:0]  in_rdst;
  logic [4:0]  in_rsrc1;
  logic [4:0]  in_rsrc2;
  logic        in_imm_mode;
  logic [15:0] in_isrc;
  logic [31:0] ir;
  logic        ir_valid;
  logic        ir_ack;
  logic        exec_done;

  modport master (
    output in_valid, in_oper_type, in_rdst, in_rsrc1, in_rsrc2,
           in_imm_mode, in_isrc, ir_ack, exec_done,
    input  in_ready, ir, ir_valid
  );

  modport slave (
    input  in_valid, in_oper_type, in_rdst, in_rsrc1, in_rsrc2,
           in_imm_mode, in_isrc, ir_ack, exec_done,
    output in_ready, ir, ir_valid
  );
endinterface

// File: rtl/instr_issue_unit_fifo.sv
// instr_fifo: DEPTH x 32 in-order buffer of encoded instruction words.
//   clk, sys_rst     : clock, async active-high reset (empties the buffer)
//   push_i, wdata_i  : write one word (ignored when full)
//   pop_i, rdata_o   : drop head word (ignored when empty); rdata_o is head
//   level_o          : registered occupancy 0..DEPTH
//   full_o, empty_o  : flags derived from level_o
module instr_fifo #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [4:0]  level_o,
  output logic        full_o,
  output logic        empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0] DEPTH_L = 5'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    level_q, level_d;
  logic          do_push, do_pop;

  assign full_o  = (level_q == DEPTH_L);
  assign empty_o = (level_q == 5'd0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 5'd1;
      2'b01:   level_d = level_q - 5'd1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the level/pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instr_issue_unit.sv
// instr_issue_unit: encodes host instructions into 32-bit words, buffers
// them in order and issues them one at a time to the core.
//   clk, sys_rst : clock, async active-high reset
//   bus          : instr_issue_unit_if.slave (host push + core issue)
//   busy         : FSM not idle or buffer non-empty
//   fifo_level   : buffer occupancy
//   issue_cnt    : completed instructions, wraps at 16 bits
//   err_illegal  : one-cycle pulse when an illegal opcode is dropped
// Build option: define ILLEGAL_OPCODE_CHECK_EN to drop opcodes above
// OP_MAX_LEGAL at push time; otherwise every opcode passes through and
// err_illegal is tied low.
//
// state        | meaning
// ST_IDLE      | no instruction in flight; pops head when buffer non-empty
// ST_ISSUE     | ir_valid high, holding ir until the core acks
// ST_WAIT_DONE | core accepted ir, waiting for exec_done
module instr_issue_unit
  import instr_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              sys_rst,
  instr_issue_unit_if.slave bus,
  output logic              busy,
  output logic [4:0]        fifo_level,
  output logic [15:0]       issue_cnt,
  output logic              err_illegal
);

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        ir_valid_q, ir_valid_d;
  logic [15:0] issue_cnt_q, issue_cnt_d;

  logic [31:0] enc_word;
  logic [31:0] head_word;
  logic        accept, store, pop;
  logic        fifo_full, fifo_empty;

  assign enc_word = encode_instr(bus.in_oper_type, bus.in_rdst, bus.in_rsrc1,
                                 bus.in_rsrc2, bus.in_imm_mode, bus.in_isrc);
  assign accept   = bus.in_valid & bus.in_ready;

`ifdef ILLEGAL_OPCODE_CHECK_EN
  logic illegal;
  logic err_illegal_q;

  // Illegal words are still handshaken so the host never stalls on them.
  assign illegal = (bus.in_oper_type > OP_MAX_LEGAL);
  assign store   = accept & ~illegal;

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) err_illegal_q <= 1'b0;
    else         err_illegal_q <= accept & illegal;
  end

  assign err_illegal = err_illegal_q;
`else
  assign store       = accept;
  assign err_illegal = 1'b0;
`endif

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .sys_rst (sys_rst),
    .push_i  (store),
    .pop_i   (pop),
    .wdata_i (enc_word),
    .rdata_o (head_word),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    ir_valid_d  = ir_valid_q;
    issue_cnt_d = issue_cnt_q;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          ir_d       = head_word;
          ir_valid_d = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.ir_ack) begin
          ir_valid_d = 1'b0;
          if (bus.exec_done) begin
            issue_cnt_d = issue_cnt_q + 16'd1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_WAIT_DONE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (bus.exec_done) begin
          issue_cnt_d = issue_cnt_q + 16'd1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        ir_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      issue_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      ir_valid_q  <= ir_valid_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign bus.in_ready = ~fifo_full;
  assign bus.ir       = ir_q;
  assign bus.ir_valid = ir_valid_q;
  assign busy         = (state_q != ST_IDLE) | ~fifo_empty;
  assign issue_cnt    = issue_cnt_q;

endmodule

// File: tb/tb_instr_issue_unit.sv
module tb_instr_issue_unit;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        busy;
  logic [4:0]  fifo_level;
  logic [15:0] issue_cnt;
  logic        err_illegal;

  int n_cmp = 0;
  int n_err = 0;

  instr_issue_unit_if bus_if ();

  instr_issue_unit #(.DEPTH(8)) dut (
    .clk         (clk),
    .sys_rst     (sys_rst),
    .bus         (bus_if),
    .busy        (busy),
    .fifo_level  (fifo_level),
    .issue_cnt   (issue_cnt),
    .err_illegal (err_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic imm, input logic [15:0] isrc);
    bus_if.in_oper_type = op;
    bus_if.in_rdst      = rd;
    bus_if.in_rsrc1     = rs1;
    bus_if.in_rsrc2     = rs2;
    bus_if.in_imm_mode  = imm;
    bus_if.in_isrc      = isrc;
    bus_if.in_valid     = 1'b1;
    step();
    bus_if.in_valid     = 1'b0;
  endtask

  task automatic ack_done();
    bus_if.ir_ack    = 1'b1;
    bus_if.exec_done = 1'b1;
    step();
    bus_if.ir_ack    = 1'b0;
    bus_if.exec_done = 1'b0;
  endtask

  task automatic wait_irv();
    int n;
    n = 0;
    while (bus_if.ir_valid !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk("wait_ir_valid", {31'd0, bus_if.ir_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    logic [15:0] exp_cnt;

    bus_if.in_valid     = 1'b0;
    bus_if.in_oper_type = '0;
    bus_if.in_rdst      = '0;
    bus_if.in_rsrc1     = '0;
    bus_if.in_rsrc2     = '0;
    bus_if.in_imm_mode  = 1'b0;
    bus_if.in_isrc      = '0;
    bus_if.ir_ack       = 1'b0;
    bus_if.exec_done    = 1'b0;
    sys_rst             = 1'b1;
    exp_cnt             = 16'd0;

    repeat (3) step();
    chk("rst_ir",       bus_if.ir, 32'h0);
    chk("rst_ir_valid", {31'd0, bus_if.ir_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    chk("rst_level",    {27'd0, fifo_level}, 32'd0);
    chk("rst_cnt",      {16'd0, issue_cnt}, 32'd0);
    chk("rst_busy",     {31'd0, busy}, 32'd0);
    chk("rst_err",      {31'd0, err_illegal}, 32'd0);
    sys_rst = 1'b0;

    // ADI: ir_valid rises on the second edge after the push
    push(5'd2, 5'd0, 5'd2, 5'd0, 1'b1, 16'd4);
    chk("adi_level1",   {27'd0, fifo_level}, 32'd1);
    chk("adi_irv_e0",   {31'd0, bus_if.ir_valid}, 32'd0);
    step();
    chk("adi_irv_e1",   {31'd0, bus_if.ir_valid}, 32'd1);
    chk("adi_ir",       bus_if.ir, 32'h10050004);
    chk("adi_level0",   {27'd0, fifo_level}, 32'd0);

    // ack without done -> WAIT_DONE, ir retained
    bus_if.ir_ack = 1'b1;
    step();
    bus_if.ir_ack = 1'b0;
    chk("adi_irv_drop", {31'd0, bus_if.ir_valid}, 32'd0);
    chk("adi_ir_keep",  bus_if.ir, 32'h10050004);
    step();
    chk("wait_busy",    {31'd0, busy}, 32'd1);
    chk("wait_cnt",     {16'd0, issue_cnt}, 32'd0);
    bus_if.exec_done = 1'b1;
    step();
    bus_if.exec_done = 1'b0;
    exp_cnt++;
    chk("adi_cnt",      {16'd0, issue_cnt}, {16'd0, exp_cnt});
    chk("adi_idle",     {31'd0, busy}, 32'd0);

    // exec_done in IDLE is ignored
    bus_if.exec_done = 1'b1;
    step();
    bus_if.exec_done = 1'b0;
    chk("idle_done_ign", {16'd0, issue_cnt}, {16'd0, exp_cnt});

    // ADD register form; exec_done without ack ignored
    push(5'd2, 5'd0, 5'd4, 5'd5, 1'b0, 16'hFFFF);
    step();
    chk("add_ir",       bus_if.ir, 32'h10082800);
    bus_if.exec_done = 1'b1;
    step();
    bus_if.exec_done = 1'b0;
    chk("issue_done_ign", {16'd0, issue_cnt}, {16'd0, exp_cnt});
    chk("issue_hold",     {31'd0, bus_if.ir_valid}, 32'd1);
    ack_done();
    exp_cnt++;
    chk("add_cnt",      {16'd0, issue_cnt}, {16'd0, exp_cnt});

    // two back-to-back pushes, same-cycle ack+done
    push(5'd4, 5'd31, 5'd1, 5'd0, 1'b1, 16'hBEEF);
    push(5'd7, 5'd3, 5'd0, 5'd31, 1'b0, 16'hFFFF);
    chk("mul_ir",       bus_if.ir, 32'h27C3BEEF);
    chk("pp_level",     {27'd0, fifo_level}, 32'd1);
    ack_done();
    exp_cnt++;
    chk("mul_cnt",      {16'd0, issue_cnt}, {16'd0, exp_cnt});
    chk("mul_irv_low",  {31'd0, bus_if.ir_valid}, 32'd0);
    step();
    chk("xor_irv",      {31'd0, bus_if.ir_valid}, 32'd1);
    chk("xor_ir",       bus_if.ir, 32'h38C0F800);
    ack_done();
    exp_cnt++;
    chk("xor_cnt",      {16'd0, issue_cnt}, {16'd0, exp_cnt});

    // fill with ir_ack held low: 10 offered, 9 accepted
    accepted = 0;
    bus_if.in_oper_type = 5'd1;
    bus_if.in_rsrc1     = 5'd0;
    bus_if.in_rsrc2     = 5'd0;
    bus_if.in_imm_mode  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus_if.in_rdst  = 5'(i);
      bus_if.in_isrc  = 16'(i);
      bus_if.in_valid = 1'b1;
      if (bus_if.in_ready === 1'b1) accepted++;
      step();
    end
    bus_if.in_valid = 1'b0;
    chk("full_accepted", 32'(accepted), 32'd9);
    chk("full_level",    {27'd0, fifo_level}, 32'd8);
    chk("full_in_ready", {31'd0, bus_if.in_ready}, 32'd0);

    for (int k = 0; k < 9; k++) begin
      wait_irv();
      chk($sformatf("drain_ir%0d", k), bus_if.ir, 32'h08010000 | (32'(k) << 22) | 32'(k));
      ack_done();
      exp_cnt++;
      if (k == 0) begin
        step();
        chk("unfull_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        chk("unfull_level",    {27'd0, fifo_level}, 32'd7);
      end
    end
    chk("drain_cnt",  {16'd0, issue_cnt}, {16'd0, exp_cnt});
    chk("drain_busy", {31'd0, busy}, 32'd0);

    // issue_cnt wrap from 0xFFFF
    force dut.issue_cnt_q = 16'hFFFF;
    step();
    release dut.issue_cnt_q;
    step();
    chk("preload_cnt", {16'd0, issue_cnt}, 32'h0000FFFF);
    push(5'd11, 5'd1, 5'd0, 5'd0, 1'b0, 16'd0);
    step();
    chk("not_ir", bus_if.ir, 32'h58400000);
    ack_done();
    exp_cnt = 16'd0;
    chk("wrap_cnt", {16'd0, issue_cnt}, 32'd0);

`ifdef ILLEGAL_OPCODE_CHECK_EN
    push(5'd13, 5'd0, 5'd0, 5'd0, 1'b0, 16'd0);
    chk("ill_err_hi", {31'd0, err_illegal}, 32'd1);
    chk("ill_level",  {27'd0, fifo_level}, 32'd0);
    step();
    chk("ill_err_lo", {31'd0, err_illegal}, 32'd0);
    chk("ill_irv",    {31'd0, bus_if.ir_valid}, 32'd0);
    chk("ill_cnt",    {16'd0, issue_cnt}, {16'd0, exp_cnt});
`else
    push(5'd13, 5'd0, 5'd0, 5'd0, 1'b0, 16'd0);
    chk("op13_err", {31'd0, err_illegal}, 32'd0);
    step();
    chk("op13_ir",  bus_if.ir, 32'h68000000);
    chk("op13_irv", {31'd0, bus_if.ir_valid}, 32'd1);
    ack_done();
    exp_cnt++;
    chk("op13_cnt", {16'd0, issue_cnt}, {16'd0, exp_cnt});
`endif

    // async reset while ISSUE with one word still queued
    push(5'd6, 5'd2, 5'd3, 5'd4, 1'b0, 16'd0);
    push(5'd5, 5'd2, 5'd3, 5'd4, 1'b0, 16'd0);
    chk("pre_rst_irv", {31'd0, bus_if.ir_valid}, 32'd1);
    #2;
    sys_rst = 1'b1;
    #1;
    chk("mid_rst_ir",       bus_if.ir, 32'h0);
    chk("mid_rst_irv",      {31'd0, bus_if.ir_valid}, 32'd0);
    chk("mid_rst_cnt",      {16'd0, issue_cnt}, 32'd0);
    chk("mid_rst_level",    {27'd0, fifo_level}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    chk("mid_rst_busy",     {31'd0, busy}, 32'd0);
    bus_if.in_oper_type = 5'd1;
    bus_if.in_rdst      = 5'd5;
    bus_if.in_rsrc1     = 5'd0;
    bus_if.in_imm_mode  = 1'b1;
    bus_if.in_isrc      = 16'h1234;
    bus_if.in_valid     = 1'b1;
    step();
    chk("rst_no_push", {27'd0, fifo_level}, 32'd0);
    sys_rst = 1'b0;
    step();
    bus_if.in_valid = 1'b0;
    chk("post_rst_push", {27'd0, fifo_level}, 32'd1);
    step();
    chk("post_rst_irv", {31'd0, bus_if.ir_valid}, 32'd1);
    chk("post_rst_ir",  bus_if.ir, 32'h09411234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_issue_unit.md
INSTR_ISSUE_UNIT -- requirements
Module: instr_issue_unit

Interface
REQ-001 Parameter: DEPTH, default 8, number of entries in the instruction buffer (power of 2, 2..16).
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 sys_rst  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1  host offers one instruction.
REQ-005 in_ready  out  1  unit can accept; push occurs when in_valid & in_ready.
REQ-006 in_oper_type  in  5  opcode field.
REQ-007 in_rdst, in_rsrc1, in_rsrc2  in  5 each  register indices.
REQ-008 in_imm_mode  in  1  1 = immediate operand, 0 = register operand.
REQ-009 in_isrc  in  16  immediate value.
REQ-010 ir  out  32  encoded instruction word presented to core.
REQ-011 ir_valid  out  1  ir holds an instruction awaiting core acceptance.
REQ-012 ir_ack  in  1  core accepts ir (sampled only while ir_valid=1).
REQ-013 exec_done  in  1  core finished the accepted instruction.
REQ-014 busy  out  1  high when FSM not IDLE or buffer non-empty.
REQ-015 fifo_level  out  5  buffer occupancy, 0..DEPTH.
REQ-016 issue_cnt  out  16  count of completed instructions.
REQ-017 err_illegal  out  1  illegal-opcode pulse (REQ-035); tied 0 when feature is compiled out.

Function
REQ-018 Encoding: ir[31:27]=oper_type, ir[26:22]=rdst, ir[21:17]=rsrc1, ir[16]=imm_mode.
REQ-019 imm_mode=1: ir[15:0]=isrc; imm_mode=0: ir[15:11]=rsrc2, ir[10:0]=0.
REQ-020 Encoding is applied at push time; buffer stores 32-bit encoded words, in order.
REQ-021 in_ready = (fifo_level != DEPTH), registered state only; no same-cycle pass-through of a pop.
REQ-022 FSM states: IDLE, ISSUE, WAIT_DONE.
REQ-023 IDLE: buffer non-empty -> pop head into ir, ir_valid<=1, go ISSUE; else stay.
REQ-024 ISSUE: ir and ir_valid held stable until ir_ack=1; on ir_ack -> ir_valid<=0, go WAIT_DONE.
REQ-025 ISSUE with ir_ack=1 and exec_done=1 same cycle -> issue_cnt+1, go IDLE directly.
REQ-026 WAIT_DONE: exec_done=1 -> issue_cnt+1, go IDLE; else stay.
REQ-027 exec_done in IDLE, or in ISSUE without ir_ack, is ignored.
REQ-028 Latency: push into empty buffer with FSM in IDLE -> ir_valid high 2 cycles later.
REQ-029 Push and pop in the same cycle: fifo_level unchanged; both operations take effect.
REQ-030 Pointers wrap modulo DEPTH; issue_cnt wraps 0xFFFF -> 0x0000.
REQ-031 ir retains last issued word after ir_valid drops.

Reset
REQ-032 sys_rst=1 (any time, including mid-handshake): state IDLE, buffer emptied, ir=0, ir_valid=0, issue_cnt=0, err_illegal=0, busy=0, fifo_level=0, in_ready=1.
REQ-033 No push, pop or count while sys_rst=1; first push is possible on the first edge after deassertion.

Configuration
REQ-034 Macro ILLEGAL_OPCODE_CHECK_EN selects opcode checking.
REQ-035 Defined: push with in_oper_type > 11 is consumed (in_ready honoured) but not stored; err_illegal=1 for exactly one cycle; issue_cnt unaffected.
REQ-036 Undefined: all opcodes stored and issued unchanged; err_illegal constant 0.

Structure
REQ-037 Package instr_pkg holds opcode constants (MOV=1, ADD=2, MUL=4, OR=5, AND=6, XOR=7, XNOR=8, NAND=9, NOR=10, NOT=11), field bit positions, and the FSM state typedef.
REQ-038 One sub-module, instr_fifo (DEPTH x 32, registered level); encoding and FSM stay in instr_issue_unit.

Verification
REQ-039 Reset: assert sys_rst mid-ISSUE -> ir=0, ir_valid=0, issue_cnt=0, fifo_level=0, in_ready=1.
REQ-040 ADI: push oper=2, rdst=0, rsrc1=2, imm=1, isrc=4 -> ir=0x10050004, ir_valid high 2 cycles after push.
REQ-041 ADD: push oper=2, rdst=0, rsrc1=4, rsrc2=5, imm=0 -> ir=0x10082800.
REQ-042 Full: ir_ack=0, push 10 back-to-back -> 9 accepted, fifo_level=8, in_ready=0; one ack+done -> in_ready=1 next cycle.
REQ-043 Same-cycle ir_ack and exec_done in ISSUE with 2 queued -> issue_cnt+1, next ir_valid 2 cycles later; preload issue_cnt to 0xFFFF -> wraps to 0.
REQ-044 With ILLEGAL_OPCODE_CHECK_EN: push oper=13 -> err_illegal 1-cycle pulse, fifo_level stays 0, ir_valid stays 0.
